// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a per-tenure hold limit.
// Define ARB_LOCK_EN to let the current owner's lock bit suppress the forced handoff.
module rr_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           any_req
);

  localparam int             HCW       = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [N-1:0]   ONE       = N'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [HCW-1:0] hold_cnt;

  logic [IDW:0]   cand;
  logic           cand_found;
  logic [IDW-1:0] cand_idx;
  logic           owner_req;
  logic           hold_full;
  logic           locked;
  logic           take_new;
  logic           go_idle;

  // Returns {found, index} of the first set mask bit at or after start, wrapping.
  function automatic logic [IDW:0] pick_rr(input logic [N-1:0] mask,
                                           input logic [IDW-1:0] start);
    logic [IDW:0] res;
    int           j;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(start) + i) % N;
      if (mask[j]) res = {1'b1, IDW'(j)};
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] idx);
    return (int'(idx) == N - 1) ? '0 : idx + IDW'(1);
  endfunction

  assign any_req    = |req;
  // Masking the owner out makes the search see only the other pending requesters.
  assign cand       = pick_rr(req & ~gnt, ptr);
  assign cand_found = cand[IDW];
  assign cand_idx   = cand[IDW-1:0];
  assign owner_req  = |(req & gnt);
  assign hold_full  = (hold_cnt == HOLD_LAST);

`ifdef ARB_LOCK_EN
  assign locked = |(lock & gnt);
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign locked      = 1'b0;
`endif

  always_comb begin
    take_new = 1'b0;
    go_idle  = 1'b0;
    if (state == IDLE) begin
      take_new = cand_found;
    end else begin
      take_new = cand_found && (!owner_req || (hold_full && !locked));
      go_idle  = !owner_req && !cand_found;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else if (take_new) begin
      state     <= GRANT;
      gnt       <= ONE << cand_idx;
      gnt_valid <= 1'b1;
      gnt_id    <= cand_idx;
      ptr       <= inc_wrap(cand_idx);
      hold_cnt  <= '0;
    end else if (go_idle) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
    end else if (state == GRANT && !hold_full) begin
      hold_cnt  <= hold_cnt + HCW'(1);
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter: directed request vectors, expected grants queued
// at drive time and compared by an independent monitor one edge later.
module tb_rr_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       any_req;

  typedef struct {
    logic [3:0] g;
    logic       a;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_fail;

  rr_bus_arbiter #(.N(4), .MAX_HOLD(8), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .any_req   (any_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] eg, input string tag);
    exp_t e;
    @(negedge clk);
    req  = r;
    lock = l;
    e.g   = eg;
    e.a   = |r;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic run(input logic [3:0] r, input logic [3:0] l,
                     input logic [3:0] eg, input int n, input string tag);
    for (int k = 0; k < n; k++) step(r, l, eg, tag);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".gnt"},       int'(gnt),       int'(e.g));
        check({e.tag, ".gnt_valid"}, int'(gnt_valid), int'(|e.g));
        check({e.tag, ".gnt_id"},    int'(gnt_id),    int'(idx_of(e.g)));
        check({e.tag, ".any_req"},   int'(any_req),   int'(e.a));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    lock = 4'b0000;

    // Reset held with every request asserted
    run(4'b1111, 4'b0000, 4'b0000, 3, "reset");
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;

    // Single requester, then drop; ptr moves to 3
    step(4'b0100, 4'b0000, 4'b0100, "single_grant");
    run (4'b0100, 4'b0000, 4'b0100, 2, "single_hold");
    step(4'b0000, 4'b0000, 4'b0000, "single_drop");
    step(4'b1001, 4'b0000, 4'b1000, "ptr_wrap_pick3");
    step(4'b0000, 4'b0000, 4'b0000, "idle_again");

    // Rotation with all requesting, 8 cycles each
    run(4'b1111, 4'b0000, 4'b0001, 8, "rot0");
    run(4'b1111, 4'b0000, 4'b0010, 8, "rot1");
    run(4'b1111, 4'b0000, 4'b0100, 8, "rot2");
    run(4'b1111, 4'b0000, 4'b1000, 8, "rot3");
    run(4'b1111, 4'b0000, 4'b0001, 8, "rot0b");
    step(4'b0000, 4'b0000, 4'b0000, "rot_release");

    // Early release: owner 1 for 3 cycles, handoff to 3 on the same edge
    run (4'b1010, 4'b0000, 4'b0010, 3, "early_own1");
    step(4'b1000, 4'b0000, 4'b1000, "early_handoff3");
    step(4'b0000, 4'b0000, 4'b0000, "early_idle");

    // Lock on owner 0
`ifdef ARB_LOCK_EN
    run(4'b0011, 4'b0001, 4'b0001, 20, "lock_hold0");
    run(4'b0011, 4'b0000, 4'b0010, 1,  "lock_release");
`else
    run(4'b0011, 4'b0001, 4'b0001, 8, "nolock_hold0");
    run(4'b0011, 4'b0001, 4'b0010, 1, "nolock_handoff");
`endif
    // A non-owner lock bit does not extend owner 1's tenure
    run (4'b0011, 4'b0001, 4'b0010, 7, "lock_nonowner");
    run (4'b0011, 4'b0001, 4'b0001, 1, "lock_nonowner_handoff");
    step(4'b0000, 4'b0000, 4'b0000, "lock_idle");

    // Async reset in the middle of owner 1's tenure
    run(4'b0010, 4'b0000, 4'b0010, 2, "pre_reset_own1");
    @(posedge clk);
    #2;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check("async_rst.gnt",       int'(gnt),       0);
    check("async_rst.gnt_valid", int'(gnt_valid), 0);
    check("async_rst.gnt_id",    int'(gnt_id),    0);
    #1;
    rst = 1'b0;
    step(4'b0011, 4'b0000, 4'b0001, "post_reset_pick0");
    step(4'b0000, 4'b0000, 4'b0000, "final_idle");

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
